// File: rtl/combat_referee_pkg.sv
// Shared types and default tuning constants for the combat referee.
package combat_referee_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIGHT = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    localparam int unsigned DEF_N_PLAYERS       = 2;
    localparam int unsigned DEF_HEALTH_W        = 11;
    localparam int unsigned DEF_MAX_HEALTH      = 300;
    localparam int unsigned DEF_DAMAGE          = 100;
    localparam int unsigned DEF_COOLDOWN_FRAMES = 30;

    // Width of a player index; a single bit even when only one index exists.
    function automatic int unsigned win_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/combat_referee_if.sv
// Control/status bundle between the game top level and the referee.
interface combat_referee_if
    import combat_referee_pkg::*;
#(
    parameter int unsigned N_PLAYERS = DEF_N_PLAYERS,
    parameter int unsigned HEALTH_W  = DEF_HEALTH_W
);
    localparam int unsigned WIN_W = win_w(N_PLAYERS);

    logic                          start;
    logic                          frame_tick;
    logic [N_PLAYERS-1:0]          hit_in;
    logic [N_PLAYERS*HEALTH_W-1:0] health_out;
    logic [N_PLAYERS-1:0]          hit_flash;
    logic [N_PLAYERS-1:0]          hit_accept;
    logic                          fighting;
    logic                          game_over;
    logic [WIN_W-1:0]              winner_id;
    logic                          draw;

    modport master (
        output start, frame_tick, hit_in,
        input  health_out, hit_flash, hit_accept, fighting, game_over, winner_id, draw
    );

    modport slave (
        input  start, frame_tick, hit_in,
        output health_out, hit_flash, hit_accept, fighting, game_over, winner_id, draw
    );

endinterface

// File: rtl/combat_referee_hit_cooldown.sv
// Per-player hit gate: invulnerability countdown plus saturating health.
module combat_referee_hit_cooldown
    import combat_referee_pkg::*;
#(
    parameter int unsigned HEALTH_W        = DEF_HEALTH_W,
    parameter int unsigned MAX_HEALTH      = DEF_MAX_HEALTH,
    parameter int unsigned DAMAGE          = DEF_DAMAGE,
    parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reload,
    input  logic                enable,
    input  logic                frame_tick,
    input  logic                hit,
    output logic [HEALTH_W-1:0] health,
    output logic                flash,
    output logic                accept
);
    localparam int unsigned CD_W = $clog2(COOLDOWN_FRAMES + 1);

    logic [CD_W-1:0]     cd;
    logic [CD_W-1:0]     cd_next;
    logic [HEALTH_W-1:0] health_next;
    logic                accept_next;

    // Next cooldown/health: reload beats accept, accept beats the frame decrement.
    always_comb begin
        cd_next     = cd;
        health_next = health;
        accept_next = 1'b0;
        if (reload) begin
            cd_next     = '0;
            health_next = HEALTH_W'(MAX_HEALTH);
        end else if (enable && hit && (cd == '0)) begin
            accept_next = 1'b1;
            cd_next     = CD_W'(COOLDOWN_FRAMES);
            if (32'(health) > DAMAGE) begin
                health_next = health - HEALTH_W'(DAMAGE);
            end else begin
                health_next = '0;
            end
        end else if (frame_tick && (cd != '0)) begin
            cd_next = cd - CD_W'(1);
        end
    end

    // Registered counter, health and the flags derived from them.
    always_ff @(posedge clk) begin
        if (rst) begin
            cd     <= '0;
            health <= HEALTH_W'(MAX_HEALTH);
            flash  <= 1'b0;
            accept <= 1'b0;
        end else begin
            cd     <= cd_next;
            health <= health_next;
            flash  <= (cd_next != '0);
            accept <= accept_next;
        end
    end

endmodule

// File: rtl/combat_referee.sv
// Round referee: IDLE/FIGHT/OVER flow, per-player damage gating, winner/draw status.
module combat_referee
    import combat_referee_pkg::*;
#(
    parameter int unsigned N_PLAYERS       = DEF_N_PLAYERS,
    parameter int unsigned HEALTH_W        = DEF_HEALTH_W,
    parameter int unsigned MAX_HEALTH      = DEF_MAX_HEALTH,
    parameter int unsigned DAMAGE          = DEF_DAMAGE,
    parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input  logic              clk,
    input  logic              rst,
    combat_referee_if.slave   bus
);
    localparam int unsigned WIN_W = win_w(N_PLAYERS);
    localparam int unsigned CNT_W = $clog2(N_PLAYERS + 1);

    state_t               state;
    state_t               state_next;
    logic                 reload;
    logic                 enable;
    logic [HEALTH_W-1:0]  health [N_PLAYERS];
    logic [N_PLAYERS-1:0] alive;
    logic [N_PLAYERS-1:0] flash;
    logic [N_PLAYERS-1:0] accept;
    logic [CNT_W-1:0]     alive_count;
    logic [WIN_W-1:0]     alive_idx;
    logic                 fighting;
    logic                 game_over;
    logic [WIN_W-1:0]     winner_id;
    logic                 draw;

    assign enable = (state == ST_FIGHT);

    for (genvar gi = 0; gi < N_PLAYERS; gi++) begin : g_player
        combat_referee_hit_cooldown #(
            .HEALTH_W        (HEALTH_W),
            .MAX_HEALTH      (MAX_HEALTH),
            .DAMAGE          (DAMAGE),
            .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
        ) u_hit_cooldown (
            .clk        (clk),
            .rst        (rst),
            .reload     (reload),
            .enable     (enable),
            .frame_tick (bus.frame_tick),
            .hit        (bus.hit_in[gi]),
            .health     (health[gi]),
            .flash      (flash[gi]),
            .accept     (accept[gi])
        );
        assign alive[gi] = (health[gi] != '0);
        assign bus.health_out[gi*HEALTH_W +: HEALTH_W] = health[gi];
    end

    // Survivor count and lowest-index survivor from registered health.
    always_comb begin
        alive_count = '0;
        alive_idx   = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (alive[i]) begin
                alive_count = alive_count + CNT_W'(1);
                alive_idx   = WIN_W'(i);
            end
        end
    end

    // Round FSM next state; a start outside FIGHT reloads every player.
    always_comb begin
        state_next = state;
        reload     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_FIGHT;
                    reload     = 1'b1;
                end
            end
            ST_FIGHT: begin
                if (alive_count <= CNT_W'(1)) begin
                    state_next = ST_OVER;
                end
            end
            ST_OVER: begin
                if (bus.start) begin
                    state_next = ST_FIGHT;
                    reload     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register, status flags and the result latched at round end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fighting  <= 1'b0;
            game_over <= 1'b0;
            winner_id <= '0;
            draw      <= 1'b0;
        end else begin
            state     <= state_next;
            fighting  <= (state_next == ST_FIGHT);
            game_over <= (state_next == ST_OVER);
            if ((state == ST_FIGHT) && (state_next == ST_OVER)) begin
                if (alive_count == CNT_W'(1)) begin
                    winner_id <= alive_idx;
                    draw      <= 1'b0;
                end else begin
                    winner_id <= '0;
                    draw      <= 1'b1;
                end
            end else if (reload) begin
                winner_id <= '0;
                draw      <= 1'b0;
            end
        end
    end

    assign bus.hit_flash  = flash;
    assign bus.hit_accept = accept;
    assign bus.fighting   = fighting;
    assign bus.game_over  = game_over;
    assign bus.winner_id  = winner_id;
    assign bus.draw       = draw;

endmodule

// File: tb/tb_combat_referee.sv
// Bench for combat_referee: scenario tasks plus an accept-event scoreboard.
module tb_combat_referee;

    localparam int unsigned HW = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    combat_referee_if #(.N_PLAYERS(2), .HEALTH_W(HW)) bus_a ();
    combat_referee_if #(.N_PLAYERS(2), .HEALTH_W(HW)) bus_b ();

    combat_referee #(
        .N_PLAYERS(2), .HEALTH_W(HW), .MAX_HEALTH(300), .DAMAGE(100), .COOLDOWN_FRAMES(30)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    combat_referee #(
        .N_PLAYERS(2), .HEALTH_W(HW), .MAX_HEALTH(250), .DAMAGE(100), .COOLDOWN_FRAMES(4)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        logic [1:0]    mask;
        logic [HW-1:0] h0;
        logic [HW-1:0] h1;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every accept pulse on dut_a must match the next expected event.
    always @(negedge clk) begin
        if (bus_a.hit_accept != 2'b00) begin
            checks++;
            if (q.size() == 0) begin
                $display("FAIL sb_unexpected_accept got=%b want=none", bus_a.hit_accept);
            end else begin
                mon_e = q.pop_front();
                if (bus_a.hit_accept !== mon_e.mask || bus_a.health_out[10:0] !== mon_e.h0 ||
                    bus_a.health_out[21:11] !== mon_e.h1)
                    $display("FAIL sb_accept got=%b/%0d/%0d want=%b/%0d/%0d", bus_a.hit_accept,
                             bus_a.health_out[10:0], bus_a.health_out[21:11], mon_e.mask, mon_e.h0, mon_e.h1);
                else
                    passed++;
            end
        end
    end

    task automatic do_reset();
        bus_a.start = 0; bus_a.frame_tick = 0; bus_a.hit_in = 2'b00;
        bus_b.start = 0; bus_b.frame_tick = 0; bus_b.hit_in = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic start_a();
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus_a.health_out !== {11'd300, 11'd300}) $display("FAIL reset_health got=%h want=%h", bus_a.health_out, {11'd300, 11'd300});
        else passed++;
        checks++;
        if ({bus_a.fighting, bus_a.game_over, bus_a.draw, bus_a.winner_id, bus_a.hit_flash, bus_a.hit_accept} !== 8'h00)
            $display("FAIL reset_flags got=%b want=0", {bus_a.fighting, bus_a.game_over, bus_a.draw, bus_a.winner_id, bus_a.hit_flash, bus_a.hit_accept});
        else passed++;
    endtask

    task automatic test_single_hit();
        do_reset();
        start_a();
        checks++;
        if (bus_a.fighting !== 1'b1) $display("FAIL start_fight got=%b want=1", bus_a.fighting);
        else passed++;
        bus_a.hit_in = 2'b01;
        q.push_back('{2'b01, 11'd200, 11'd300});
        step();
        bus_a.hit_in = 2'b00;
        checks++;
        if (bus_a.health_out !== {11'd300, 11'd200}) $display("FAIL hit1_health got=%0d/%0d want=200/300", bus_a.health_out[10:0], bus_a.health_out[21:11]);
        else passed++;
        checks++;
        if ({bus_a.hit_accept, bus_a.hit_flash} !== 4'b0101) $display("FAIL hit1_flags got=%b want=0101", {bus_a.hit_accept, bus_a.hit_flash});
        else passed++;
        step();
        checks++;
        if (bus_a.hit_accept !== 2'b00) $display("FAIL hit1_pulse got=%b want=00", bus_a.hit_accept);
        else passed++;
    endtask

    task automatic test_held_cooldown();
        int n_acc = 0;
        int e0 = -1;
        int e1 = -1;
        do_reset();
        start_a();
        bus_a.hit_in = 2'b01;
        bus_a.frame_tick = 1'b1;
        q.push_back('{2'b01, 11'd200, 11'd300});
        q.push_back('{2'b01, 11'd100, 11'd300});
        for (int k = 0; k < 33; k++) begin
            step();
            if (bus_a.hit_accept[0]) begin
                if (n_acc == 0) e0 = k;
                else if (n_acc == 1) e1 = k;
                n_acc++;
            end
        end
        bus_a.hit_in = 2'b00;
        bus_a.frame_tick = 1'b0;
        checks++;
        if (n_acc != 2 || e0 != 0 || e1 != 31) $display("FAIL held_accepts got=%0d@%0d,%0d want=2@0,31", n_acc, e0, e1);
        else passed++;
        checks++;
        if (bus_a.health_out[10:0] !== 11'd100) $display("FAIL held_health got=%0d want=100", bus_a.health_out[10:0]);
        else passed++;
    endtask

    task automatic test_knockout();
        logic [1:0] acc = 2'b00;
        bus_a.frame_tick = 1'b1;
        repeat (30) step();
        bus_a.frame_tick = 1'b0;
        bus_a.hit_in = 2'b01;
        q.push_back('{2'b01, 11'd0, 11'd300});
        step();
        bus_a.hit_in = 2'b00;
        checks++;
        if ({bus_a.health_out[10:0], bus_a.game_over} !== {11'd0, 1'b0}) $display("FAIL ko_t1 got=%0d/%b want=0/0", bus_a.health_out[10:0], bus_a.game_over);
        else passed++;
        step();
        checks++;
        if ({bus_a.game_over, bus_a.fighting, bus_a.winner_id, bus_a.draw} !== 4'b1010)
            $display("FAIL ko_result got=%b want=1010", {bus_a.game_over, bus_a.fighting, bus_a.winner_id, bus_a.draw});
        else passed++;
        bus_a.hit_in = 2'b10;
        bus_a.frame_tick = 1'b1;
        repeat (3) begin
            step();
            acc = acc | bus_a.hit_accept;
        end
        bus_a.hit_in = 2'b00;
        bus_a.frame_tick = 1'b0;
        checks++;
        if ({bus_a.health_out[21:11], acc} !== {11'd300, 2'b00}) $display("FAIL over_ignore got=%0d/%b want=300/00", bus_a.health_out[21:11], acc);
        else passed++;
    endtask

    task automatic test_double_ko();
        logic [HW-1:0] h;
        do_reset();
        start_a();
        for (int r = 0; r < 3; r++) begin
            h = HW'(300 - 100 * (r + 1));
            bus_a.hit_in = 2'b11;
            q.push_back('{2'b11, h, h});
            step();
            bus_a.hit_in = 2'b00;
            checks++;
            if (bus_a.health_out !== {h, h}) $display("FAIL dbl_health%0d got=%h want=%h", r, bus_a.health_out, {h, h});
            else passed++;
            if (r < 2) begin
                bus_a.frame_tick = 1'b1;
                repeat (31) step();
                bus_a.frame_tick = 1'b0;
            end
        end
        step();
        checks++;
        if ({bus_a.game_over, bus_a.draw, bus_a.winner_id} !== 3'b110) $display("FAIL dbl_draw got=%b want=110", {bus_a.game_over, bus_a.draw, bus_a.winner_id});
        else passed++;
    endtask

    task automatic test_saturation();
        logic [HW-1:0] exp_h [3];
        exp_h[0] = 11'd150; exp_h[1] = 11'd50; exp_h[2] = 11'd0;
        do_reset();
        bus_b.start = 1'b1;
        step();
        bus_b.start = 1'b0;
        for (int r = 0; r < 3; r++) begin
            bus_b.hit_in = 2'b01;
            step();
            bus_b.hit_in = 2'b00;
            checks++;
            if (bus_b.health_out[10:0] !== exp_h[r]) $display("FAIL sat_health%0d got=%0d want=%0d", r, bus_b.health_out[10:0], exp_h[r]);
            else passed++;
            bus_b.frame_tick = 1'b1;
            repeat (5) step();
            bus_b.frame_tick = 1'b0;
        end
        checks++;
        if ({bus_b.game_over, bus_b.winner_id, bus_b.draw} !== 3'b110) $display("FAIL sat_result got=%b want=110", {bus_b.game_over, bus_b.winner_id, bus_b.draw});
        else passed++;
        bus_b.start = 1'b1;
        step();
        bus_b.start = 1'b0;
        checks++;
        if ({bus_b.health_out, bus_b.fighting, bus_b.game_over} !== {11'd250, 11'd250, 1'b1, 1'b0})
            $display("FAIL restart got=%0d/%0d/%b%b want=250/250/10", bus_b.health_out[10:0], bus_b.health_out[21:11], bus_b.fighting, bus_b.game_over);
        else passed++;
    endtask

    task automatic test_reset_mid_fight();
        do_reset();
        start_a();
        bus_a.hit_in = 2'b01;
        q.push_back('{2'b01, 11'd200, 11'd300});
        step();
        bus_a.hit_in = 2'b00;
        bus_a.frame_tick = 1'b1;
        repeat (15) step();
        bus_a.frame_tick = 1'b0;
        checks++;
        if (bus_a.hit_flash !== 2'b01) $display("FAIL mid_flash got=%b want=01", bus_a.hit_flash);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus_a.health_out, bus_a.hit_flash, bus_a.fighting, bus_a.game_over} !== {11'd300, 11'd300, 2'b00, 1'b0, 1'b0})
            $display("FAIL mid_reset got=%h/%b/%b%b want=%h/00/00", bus_a.health_out, bus_a.hit_flash, bus_a.fighting, bus_a.game_over, {11'd300, 11'd300});
        else passed++;
        start_a();
        bus_a.hit_in = 2'b01;
        q.push_back('{2'b01, 11'd200, 11'd300});
        step();
        bus_a.hit_in = 2'b00;
        bus_a.start = 1'b1;
        step();
        bus_a.start = 1'b0;
        checks++;
        if ({bus_a.health_out[10:0], bus_a.fighting} !== {11'd200, 1'b1}) $display("FAIL start_in_fight got=%0d/%b want=200/1", bus_a.health_out[10:0], bus_a.fighting);
        else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_hit();
        test_held_cooldown();
        test_knockout();
        test_double_ko();
        test_saturation();
        test_reset_mid_fight();
        step();
        checks++;
        if (q.size() != 0) $display("FAIL sb_pending got=%0d want=0", q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
